seq_match_window_counter: RTL and testbench

Downstream consumer of the programmable sequence detector's one-bit `seen` strobe. Counts detector matches over back-to-back windows of programmable length. Publishes each window's total through a single-entry valid/ready output register, so a slower monitor or CSR stage can drain match-rate statistics.

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_match_window_counter_if.sv | 30 +++
 rtl/match_result_reg.sv | 40 ++++
 rtl/seq_match_window_counter.sv | 131 +++++++++++++
 tb/tb_seq_match_window_counter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-match window counter and related monitors.
package seq_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } seq_state_e;

    // Window result as published downstream; kept at default widths for reuse.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic                 sat;
    } match_result_t;

endpackage

// File: rtl/seq_match_window_counter_if.sv
// Result channel of the window counter: one window total per accepted transfer.
interface seq_match_window_counter_if
    import seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    // A transfer happens on a rising clock edge where out_valid && out_ready.
    // While out_valid is high and out_ready low, out_count/out_sat hold steady;
    // out_valid never depends combinationally on out_ready.
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output out_valid,
        output out_count,
        output out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_count,
        input  out_sat,
        output out_ready
    );

endinterface

// File: rtl/match_result_reg.sv
// Single-entry valid/ready holding register; a new offer while full and not
// draining is discarded and flagged in a sticky drop bit.
module match_result_reg #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         offer,
    input  logic [W-1:0] offer_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         dropped
);

    logic load;
    logic drain;

    assign drain = valid && ready;
    assign load  = offer && (!valid || ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            data    <= '0;
            dropped <= 1'b0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                data  <= offer_data;
            end else if (drain) begin
                valid <= 1'b0;
            end
            if (offer && !load) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_match_window_counter.sv
// Counts detector matches over back-to-back programmable windows and publishes
// each total. Define MATCH_CNT_SAT_EN for a saturating tally with out_sat.
module seq_match_window_counter
    import seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          seen,
    input  logic [WIN_W-1:0]              win_len,
    seq_match_window_counter_if.master    res,
    output logic                          dropped,
    output logic                          busy,
    output seq_state_e                    fsm_state
);

    seq_state_e       state_q, state_d;
    logic [WIN_W-1:0] idx_q, idx_d;
    logic [WIN_W-1:0] len_q, len_d, len_cur;
    logic [CNT_W-1:0] tally_q, tally_d;
    logic [CNT_W-1:0] base, sum;
    logic             first, close, offer;
    logic             offer_sat;
    logic [CNT_W:0]   held;

    // On a window's first cycle the running tally is replaced, not extended,
    // so the previous window's final never leaks into the next one.
    always_comb begin
        first   = (idx_q == '0);
        len_cur = first ? ((win_len == '0) ? WIN_W'(1) : win_len) : len_q;
        base    = first ? '0 : tally_q;
        close   = (idx_q == (len_cur - WIN_W'(1)));
    end

`ifdef MATCH_CNT_SAT_EN
    logic sat_q, sat_d, base_sat;

    always_comb begin
        base_sat = first ? 1'b0 : sat_q;
        if (seen && (&base)) begin
            sum       = base;
            offer_sat = 1'b1;
        end else begin
            sum       = base + CNT_W'(seen);
            offer_sat = base_sat;
        end
        sat_d = ((state_q == COUNT) && enable) ? offer_sat : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`else
    assign sum       = base + CNT_W'(seen);
    assign offer_sat = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        tally_d = tally_q;
        offer   = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d   = '0;
                tally_d = '0;
                if (enable) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (first) begin
                    len_d = len_cur;
                end
                tally_d = sum;
                offer   = close;
                idx_d   = close ? '0 : (idx_q + WIN_W'(1));
                // Abort drops the partial window; a close on this cycle still goes out.
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tally_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            tally_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            tally_q <= tally_d;
        end
    end

    match_result_reg #(
        .W(CNT_W + 1)
    ) u_result (
        .clk        (clk),
        .reset      (reset),
        .offer      (offer),
        .offer_data ({sum, offer_sat}),
        .ready      (res.out_ready),
        .valid      (res.out_valid),
        .data       (held),
        .dropped    (dropped)
    );

    assign res.out_count = held[CNT_W:1];
    assign res.out_sat   = held[0];
    assign busy          = (state_q == COUNT);
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_seq_match_window_counter.sv
// Scoreboard bench for seq_match_window_counter: directed scenarios plus random
// traffic checked against a window-level arithmetic model.
module tb_seq_match_window_counter;
    import seq_pkg::*;

    localparam int CNT_W = 3;
    localparam int WIN_W = 4;
    localparam int MAXV  = (1 << CNT_W) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic seen = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic dropped;
    logic busy;
    seq_state_e fsm_state;

    seq_match_window_counter_if #(.CNT_W(CNT_W)) res_if ();

    seq_match_window_counter #(
        .CNT_W(CNT_W),
        .WIN_W(WIN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .seen      (seen),
        .win_len   (win_len),
        .res       (res_if),
        .dropped   (dropped),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    logic [CNT_W:0] exp_q[$];

    // reference model: window position, running integer sum, result slot
    bit m_busy, m_valid, m_dropped;
    int m_pos, m_len, m_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_valid = 0; m_dropped = 0;
        m_pos = 0; m_len = 1; m_sum = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit en, input bit s, input int wl, input bit rdy);
        bit offer = 0;
        int f = 0;
        bit fs = 0;
        logic [CNT_W-1:0] fc;
        bit was_valid = m_valid;
        if (!m_busy) begin
            if (en) begin
                m_busy = 1;
                m_pos = 0;
            end
        end else begin
            if (m_pos == 0) begin
                m_len = (wl == 0) ? 1 : wl;
                m_sum = 0;
            end
            m_sum += s;
            if (m_pos == m_len - 1) begin
                offer = 1;
`ifdef MATCH_CNT_SAT_EN
                f  = (m_sum > MAXV) ? MAXV : m_sum;
                fs = (m_sum > MAXV);
`else
                f  = m_sum % (MAXV + 1);
                fs = 0;
`endif
                m_pos = 0;
            end else begin
                m_pos++;
            end
            if (!en) begin
                m_busy = 0;
                m_pos = 0;
            end
        end
        if (offer) begin
            if (!was_valid || rdy) begin
                m_valid = 1;
                fc = f[CNT_W-1:0];
                exp_q.push_back({fc, fs});
            end else begin
                m_dropped = 1;
            end
        end else if (was_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    // driver tasks
    task automatic cycle(input bit en, input bit s, input int wl, input bit rdy);
        enable = en;
        seen = s;
        win_len = WIN_W'(wl);
        res_if.out_ready = rdy;
        @(posedge clk);
        #1;
        model_edge(en, s, wl, rdy);
    endtask

    task automatic run_seq(input bit en, input int wl, input bit rdy, input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) cycle(en, pat[i], wl, rdy);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", res_if.out_valid, 0);
        check("rst_out_count", res_if.out_count, 0);
        check("rst_out_sat", res_if.out_sat, 0);
        check("rst_dropped", dropped, 0);
        check("rst_busy", busy, 0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // monitor: compares status every cycle, pops a result on each transfer
    always @(negedge clk) begin
        logic [CNT_W:0] e;
        check("busy", busy, m_busy);
        check("dropped", dropped, m_dropped);
        check("out_valid", res_if.out_valid, m_valid);
        if (res_if.out_valid && res_if.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL result_unexpected: got count %0d with no expected entry at %0t",
                         res_if.out_count, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_count", res_if.out_count, e[CNT_W:1]);
                check("out_sat", res_if.out_sat, e[0]);
            end
        end
    end

    initial begin
        int seg_wl, p_rdy, p_seen;
        bit en, s, rdy;
        int wl;
        model_reset();
        res_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        // window of 4 with seen 1,0,1,1 held, then the next window runs gap-free
        cycle(1, 0, 4, 0);
        run_seq(1, 4, 0, 32'b1101, 4);
        run_seq(1, 4, 1, 32'b0110, 4);
        repeat (3) cycle(0, 0, 0, 1);

        // win_len 0 acts as 1: one result per cycle, nothing dropped
        cycle(1, 0, 0, 1);
        run_seq(1, 0, 1, 32'b101, 3);
        repeat (3) cycle(0, 0, 0, 1);

        // two windows of 2 with no consumer: second dropped, sticky flag
        cycle(1, 0, 2, 0);
        run_seq(1, 2, 0, 32'b0111, 4);
        cycle(0, 0, 2, 1);
        repeat (3) cycle(0, 0, 0, 0);

        // abort at window cycle 5, then a fresh window
        cycle(1, 0, 8, 1);
        run_seq(1, 8, 1, 32'b11111, 5);
        cycle(0, 1, 8, 1);
        cycle(0, 0, 8, 1);
        cycle(1, 0, 3, 1);
        run_seq(1, 3, 1, 32'b010, 3);
        repeat (2) cycle(0, 0, 0, 1);

        // overflow: 9 matches into a 3-bit tally
        cycle(1, 0, 9, 1);
        run_seq(1, 9, 1, 32'h1ff, 9);
        repeat (3) cycle(0, 0, 0, 1);

        // reset mid-window with a result held and the drop flag set
        do_reset();
        cycle(1, 0, 2, 0);
        run_seq(1, 2, 0, 32'b1111, 5);
        do_reset();
        repeat (2) cycle(0, 0, 0, 1);

        // random traffic
        seg_wl = 3; p_rdy = 50; p_seen = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                seg_wl = $urandom_range(0, 15);
                p_rdy = $urandom_range(10, 100);
                p_seen = $urandom_range(0, 100);
            end
            if (i == 1500) do_reset();
            en = ($urandom_range(0, 59) != 0);
            s = ($urandom_range(1, 100) <= p_seen);
            rdy = ($urandom_range(1, 100) <= p_rdy);
            wl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : seg_wl;
            cycle(en, s, wl, rdy);
        end

        repeat (20) cycle(0, 0, 0, 1);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
